uart_tx_arb: RTL and testbench



---
 rtl/uart_tx_arb_pkg.sv | 38 +++
 rtl/uart_tx_arb_pick.sv | 40 ++++
 rtl/uart_tx_arb.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the UART transmit arbiter family.
// Holds the FSM state enum, the byte width and a software round-robin helper.
package uart_tx_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } pick_t;

    // Scan vld from ptr upward with wrap over n entries (n <= 8).
    // Descending walk so the closest set entry to ptr is the last written.
    function automatic pick_t rr_pick(
        input logic [7:0] vld,
        input logic [2:0] ptr,
        input int         n
    );
        pick_t r;
        int    j;
        r = '0;
        for (int k = n - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (vld[j]) begin
                r.hit = 1'b1;
                r.idx = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arb_pick.sv
// Combinational N-way round-robin priority finder: rotate, find-first, unrotate.
// Ports: vld (requests), ptr (highest-priority index), hit, idx (winner).
module rr_pick_n
    import uart_tx_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         vld,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 hit,
    output logic [$clog2(N)-1:0] idx
);

    localparam int            IW = $clog2(N);
    localparam logic [IW:0]   SN = (IW + 1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  k;
    logic [IW:0]    sum;

    always_comb begin
        dbl = {vld, vld} >> ptr;
        rot = dbl[N-1:0];
        hit = 1'b0;
        k   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                hit = 1'b1;
                k   = IW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, k};
        if (sum >= SN) begin
            sum = sum - SN;
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter among N requesters.
// Ports: clk, resetn (async low), req_vld/req_data/req_last in, req_rdy out,
// uart_tx_vld/uart_tx_data out, uart_tx_busy in, grant_active, grant_id, pkt_cnt.
// Optional UART_TX_ARB_TIMEOUT_EN: force-close stalled packets, adds drop_cnt.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = BYTE_W
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         req_vld,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_rdy,
    output logic                 uart_tx_vld,
    output logic [W-1:0]         uart_tx_data,
    input  logic                 uart_tx_busy,
`ifdef UART_TX_ARB_TIMEOUT_EN
    output logic [7:0]           drop_cnt,
`endif
    output logic                 grant_active,
    output logic [$clog2(N)-1:0] grant_id,
    output logic [15:0]          pkt_cnt
);

    localparam int IW = $clog2(N);

    state_t        state, state_n;
    logic [IW-1:0] gid_n;
    logic          gact_n;
    logic [IW-1:0] rr_ptr, rr_n;
    logic [IW-1:0] gid_inc;
    logic [15:0]   cnt_n;
    logic          pkt_done, done_n;
    logic          issue;
    logic          hit;
    logic [IW-1:0] pick;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]    drop_n;
`endif

    rr_pick_n #(.N(N)) u_pick (
        .vld (req_vld),
        .ptr (rr_ptr),
        .hit (hit),
        .idx (pick)
    );

    assign gid_inc = (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
    assign issue   = (state == SEND) && req_vld[grant_id] && !uart_tx_busy;

    // Data is zero outside an issue so the bus is quiet between bytes.
    always_comb begin
        req_rdy      = '0;
        req_rdy[grant_id] = issue;
        uart_tx_vld  = issue;
        uart_tx_data = issue ? req_data[grant_id*W +: W] : '0;
    end

    always_comb begin
        state_n = state;
        gid_n   = grant_id;
        gact_n  = grant_active;
        rr_n    = rr_ptr;
        cnt_n   = pkt_cnt;
        done_n  = pkt_done;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_n   = tmo;
        drop_n  = drop_cnt;
`endif
        unique case (state)
            IDLE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                tmo_n = '0;
`endif
                if (hit) begin
                    gid_n   = pick;
                    gact_n  = 1'b1;
                    done_n  = 1'b0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (issue) begin
                    state_n = GAP;
                    done_n  = req_last[grant_id];
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmo_n   = '0;
`endif
                    if (req_last[grant_id]) begin
                        rr_n = gid_inc;
                        if (pkt_cnt != 16'hFFFF) begin
                            cnt_n = pkt_cnt + 16'd1;
                        end
                    end
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (!req_vld[grant_id]) begin
                    if (tmo == TW'(TIMEOUT - 1)) begin
                        state_n = IDLE;
                        gact_n  = 1'b0;
                        rr_n    = gid_inc;
                        tmo_n   = '0;
                        if (drop_cnt != 8'hFF) begin
                            drop_n = drop_cnt + 8'd1;
                        end
                    end else begin
                        tmo_n = tmo + 1'b1;
                    end
                end
`endif
            end
            GAP: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                tmo_n = '0;
`endif
                // Busy is ignored here: the UART raises it a cycle after issue.
                if (pkt_done) begin
                    state_n = IDLE;
                    gact_n  = 1'b0;
                end else begin
                    state_n = SEND;
                end
            end
            default: begin
                state_n = IDLE;
                gact_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            grant_id     <= '0;
            grant_active <= 1'b0;
            rr_ptr       <= '0;
            pkt_cnt      <= '0;
            pkt_done     <= 1'b0;
        end else begin
            state        <= state_n;
            grant_id     <= gid_n;
            grant_active <= gact_n;
            rr_ptr       <= rr_n;
            pkt_cnt      <= cnt_n;
            pkt_done     <= done_n;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo      <= '0;
            drop_cnt <= '0;
        end else begin
            tmo      <= tmo_n;
            drop_cnt <= drop_n;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with two requester FIFO models and a UART busy model.
// Timeout scenario is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_vld;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_rdy;
    logic        uart_tx_vld;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic        grant_active;
    logic [0:0]  grant_id;
    logic [15:0] pkt_cnt;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [7:0]  drop_cnt;
`endif

    logic [7:0]  mem [2][64];
    logic        lst [2][64];
    int          len [2] = '{0, 0};
    int          rp  [2] = '{0, 0};
    logic        force_busy = 1'b0;
    int          bcnt = 0;
    logic [7:0]  log_d [$];
    int          log_g [$];
    int          viol = 0;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N(2)
`ifdef UART_TX_ARB_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_vld      (req_vld),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_rdy      (req_rdy),
        .uart_tx_vld  (uart_tx_vld),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
`ifdef UART_TX_ARB_TIMEOUT_EN
        .drop_cnt     (drop_cnt),
`endif
        .grant_active (grant_active),
        .grant_id     (grant_id),
        .pkt_cnt      (pkt_cnt)
    );

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req_vld[i]         = rp[i] < len[i];
            req_data[i*8 +: 8] = mem[i][rp[i] % 64];
            req_last[i]        = lst[i][rp[i] % 64];
        end
    end

    assign uart_tx_busy = force_busy || (bcnt != 0);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) bcnt <= 0;
        else if (uart_tx_vld) bcnt <= 10;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (req_rdy[i]) rp[i] <= rp[i] + 1;
        if (uart_tx_vld) begin
            log_d.push_back(uart_tx_data);
            log_g.push_back(req_rdy[1] ? 1 : 0);
            if (uart_tx_busy) viol <= viol + 1;
        end
        if (uart_tx_vld != (|req_rdy)) viol <= viol + 1;
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        mem[i][len[i]] = d;
        lst[i][len[i]] = l;
        len[i]++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_log(input int n, input int maxc);
        int c = 0;
        while (log_d.size() < n && c < maxc) begin
            @(negedge clk);
            c++;
        end
        ncmp++;
        if (log_d.size() < n) begin
            $display("FAIL wait_log got %0d exp %0d", log_d.size(), n);
            nfail++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        ncmp += 6;
        if (req_rdy !== 2'b00) begin
            $display("FAIL rst_rdy got %b exp 00", req_rdy); nfail++;
        end
        if (uart_tx_vld !== 1'b0) begin
            $display("FAIL rst_vld got %b exp 0", uart_tx_vld); nfail++;
        end
        if (uart_tx_data !== 8'h00) begin
            $display("FAIL rst_data got %h exp 00", uart_tx_data); nfail++;
        end
        if (grant_active !== 1'b0) begin
            $display("FAIL rst_gact got %b exp 0", grant_active); nfail++;
        end
        if (grant_id !== 1'b0) begin
            $display("FAIL rst_gid got %b exp 0", grant_id); nfail++;
        end
        if (pkt_cnt !== 16'd0) begin
            $display("FAIL rst_pkt got %0d exp 0", pkt_cnt); nfail++;
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] ed [3] = '{8'h41, 8'h42, 8'h43};
        int base = log_d.size();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        wait_log(base + 3, 200);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ncmp += 2;
            if (log_d[base+k] !== ed[k]) begin
                $display("FAIL single_d%0d got %h exp %h", k, log_d[base+k], ed[k]);
                nfail++;
            end
            if (log_g[base+k] != 0) begin
                $display("FAIL single_g%0d got %0d exp 0", k, log_g[base+k]);
                nfail++;
            end
        end
        ncmp += 4;
        if (log_d.size() != base + 3) begin
            $display("FAIL single_n got %0d exp %0d", log_d.size(), base + 3); nfail++;
        end
        if (pkt_cnt !== 16'd1) begin
            $display("FAIL single_pkt got %0d exp 1", pkt_cnt); nfail++;
        end
        if (grant_active !== 1'b0) begin
            $display("FAIL single_gact got %b exp 0", grant_active); nfail++;
        end
        if (viol != 0) begin
            $display("FAIL single_ovl got %0d exp 0", viol); nfail++;
        end
    endtask

    task automatic test_rr();
        logic [7:0] ed [8] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1,
                               8'hA2, 8'hA3, 8'hB2, 8'hB3};
        int eg [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int base;
        do_reset();
        base = log_d.size();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b1);
        push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b0); push(1, 8'hB3, 1'b1);
        wait_log(base + 8, 400);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            ncmp += 2;
            if (log_d[base+k] !== ed[k]) begin
                $display("FAIL rr_d%0d got %h exp %h", k, log_d[base+k], ed[k]);
                nfail++;
            end
            if (log_g[base+k] != eg[k]) begin
                $display("FAIL rr_g%0d got %0d exp %0d", k, log_g[base+k], eg[k]);
                nfail++;
            end
        end
        ncmp++;
        if (pkt_cnt !== 16'd4) begin
            $display("FAIL rr_pkt got %0d exp 4", pkt_cnt); nfail++;
        end
    endtask

    task automatic test_hold();
        logic [7:0] ed [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hD0};
        int eg [4] = '{0, 0, 0, 1};
        int base;
        do_reset();
        base = log_d.size();
        push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b1);
        wait_log(base + 1, 50);
        push(1, 8'hD0, 1'b1);
        wait_log(base + 4, 200);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            ncmp += 2;
            if (log_d[base+k] !== ed[k]) begin
                $display("FAIL hold_d%0d got %h exp %h", k, log_d[base+k], ed[k]);
                nfail++;
            end
            if (log_g[base+k] != eg[k]) begin
                $display("FAIL hold_g%0d got %0d exp %0d", k, log_g[base+k], eg[k]);
                nfail++;
            end
        end
    endtask

    task automatic test_busy();
        int base;
        do_reset();
        base = log_d.size();
        force_busy = 1'b1;
        push(0, 8'hE0, 1'b1);
        repeat (50) @(negedge clk);
        ncmp += 3;
        if (log_d.size() != base) begin
            $display("FAIL busy_quiet got %0d exp %0d", log_d.size(), base); nfail++;
        end
        if (grant_active !== 1'b1) begin
            $display("FAIL busy_gact got %b exp 1", grant_active); nfail++;
        end
        if (req_rdy !== 2'b00) begin
            $display("FAIL busy_rdy got %b exp 00", req_rdy); nfail++;
        end
        force_busy = 1'b0;
        wait_log(base + 1, 20);
        repeat (15) @(negedge clk);
        ncmp += 3;
        if (log_d[base] !== 8'hE0) begin
            $display("FAIL busy_d got %h exp E0", log_d[base]); nfail++;
        end
        if (log_d.size() != base + 1) begin
            $display("FAIL busy_n got %0d exp %0d", log_d.size(), base + 1); nfail++;
        end
        if (pkt_cnt !== 16'd1) begin
            $display("FAIL busy_pkt got %0d exp 1", pkt_cnt); nfail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ed [3] = '{8'hF0, 8'h91, 8'h92};
        int eg [3] = '{0, 1, 1};
        int base;
        do_reset();
        base = log_d.size();
        push(1, 8'h90, 1'b0); push(1, 8'h91, 1'b0); push(1, 8'h92, 1'b1);
        wait_log(base + 1, 50);
        push(0, 8'hF0, 1'b1);
        repeat (3) @(negedge clk);
        ncmp += 2;
        if (grant_active !== 1'b1 || grant_id !== 1'b1) begin
            $display("FAIL mid_pre got %b/%b exp 1/1", grant_active, grant_id);
            nfail++;
        end
        if (log_g[base] != 1) begin
            $display("FAIL mid_g0 got %0d exp 1", log_g[base]); nfail++;
        end
        #2;
        resetn = 1'b0;
        #1;
        ncmp += 4;
        if (grant_active !== 1'b0) begin
            $display("FAIL mid_gact got %b exp 0", grant_active); nfail++;
        end
        if (grant_id !== 1'b0) begin
            $display("FAIL mid_gid got %b exp 0", grant_id); nfail++;
        end
        if (req_rdy !== 2'b00 || uart_tx_vld !== 1'b0) begin
            $display("FAIL mid_out got %b/%b exp 00/0", req_rdy, uart_tx_vld);
            nfail++;
        end
        if (uart_tx_data !== 8'h00) begin
            $display("FAIL mid_data got %h exp 00", uart_tx_data); nfail++;
        end
        @(negedge clk);
        resetn = 1'b1;
        wait_log(base + 4, 200);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ncmp += 2;
            if (log_d[base+1+k] !== ed[k]) begin
                $display("FAIL mid_d%0d got %h exp %h", k, log_d[base+1+k], ed[k]);
                nfail++;
            end
            if (log_g[base+1+k] != eg[k]) begin
                $display("FAIL mid_g%0d got %0d exp %0d", k, log_g[base+1+k], eg[k]);
                nfail++;
            end
        end
        ncmp++;
        if (pkt_cnt !== 16'd2) begin
            $display("FAIL mid_pkt got %0d exp 2", pkt_cnt); nfail++;
        end
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int base;
        do_reset();
        base = log_d.size();
        push(0, 8'h70, 1'b0);
        push(1, 8'h80, 1'b1);
        wait_log(base + 1, 50);
        repeat (10) @(negedge clk);
        ncmp += 2;
        if (grant_active !== 1'b1 || grant_id !== 1'b0) begin
            $display("FAIL tmo_hold got %b/%b exp 1/0", grant_active, grant_id);
            nfail++;
        end
        if (pkt_cnt !== 16'd0) begin
            $display("FAIL tmo_pkt0 got %0d exp 0", pkt_cnt); nfail++;
        end
        wait_log(base + 2, 60);
        repeat (4) @(negedge clk);
        ncmp += 4;
        if (log_d[base+1] !== 8'h80 || log_g[base+1] != 1) begin
            $display("FAIL tmo_next got %h/%0d exp 80/1", log_d[base+1], log_g[base+1]);
            nfail++;
        end
        if (drop_cnt !== 8'd1) begin
            $display("FAIL tmo_drop got %0d exp 1", drop_cnt); nfail++;
        end
        if (pkt_cnt !== 16'd1) begin
            $display("FAIL tmo_pkt got %0d exp 1", pkt_cnt); nfail++;
        end
        if (grant_active !== 1'b0) begin
            $display("FAIL tmo_gact got %b exp 0", grant_active); nfail++;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++) begin
                mem[i][j] = 8'h00;
                lst[i][j] = 1'b0;
            end
        test_reset();
        test_single();
        test_rr();
        test_hold();
        test_busy();
        test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        ncmp++;
        if (viol != 0) begin
            $display("FAIL protocol got %0d exp 0", viol); nfail++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
